// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature encoder front end.
// Holds the FSM state type and the clockwise Gray-code successor table.
package quad_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ARM   = 2'd1,
    TRACK = 2'd2
  } quad_state_e;

  localparam logic [1:0] CW_NEXT_00 = 2'b01;
  localparam logic [1:0] CW_NEXT_01 = 2'b11;
  localparam logic [1:0] CW_NEXT_11 = 2'b10;
  localparam logic [1:0] CW_NEXT_10 = 2'b00;

  function automatic logic [1:0] cw_next(input logic [1:0] ab);
    logic [1:0] n;
    case (ab)
      2'b00:   n = CW_NEXT_00;
      2'b01:   n = CW_NEXT_01;
      2'b11:   n = CW_NEXT_11;
      default: n = CW_NEXT_10;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/quad_debounce.sv
// One encoder channel: 2-FF synchroniser followed by a persistence filter.
// load bypasses the filter so the decoder can arm from a known level.
module quad_debounce
  import quad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic load,
  output logic sync_out,
  output logic filtered
);

  localparam logic [7:0] LIM = 8'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [7:0]             cnt;

  assign sync_out = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync     <= '0;
      cnt      <= '0;
      filtered <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      if (load) begin
        filtered <= sync_out;
        cnt      <= '0;
      end else if (sync_out == filtered) begin
        cnt <= '0;
      end else if (cnt == LIM) begin
        // level has persisted long enough to be believed
        filtered <= sync_out;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder stage: debounced A/B in, cw/ccw step pulses out.
// Keeps a wrapping signed position and a sticky illegal-transition flag.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int POS_WIDTH       = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enc_a,
  input  logic                        enc_b,
  input  logic                        en,
  input  logic                        err_clr,
  output logic                        cw_pulse,
  output logic                        ccw_pulse,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        err_flag,
  output logic                        tracking
);

  quad_state_e state;
  logic [1:0]  fill_cnt;
  logic [1:0]  prev_ab;
  logic [1:0]  ab;
  logic        sync_a;
  logic        sync_b;
  logic        filt_a;
  logic        filt_b;
  logic        load;
  logic        is_cw;
  logic        is_ccw;
  logic        is_err;

  assign load = (state == ARM);

  quad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk      (clk),
    .reset    (reset),
    .raw      (enc_a),
    .load     (load),
    .sync_out (sync_a),
    .filtered (filt_a)
  );

  quad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk      (clk),
    .reset    (reset),
    .raw      (enc_b),
    .load     (load),
    .sync_out (sync_b),
    .filtered (filt_b)
  );

  assign ab       = {filt_a, filt_b};
  assign tracking = (state == TRACK);

  always_comb begin
    is_cw  = 1'b0;
    is_ccw = 1'b0;
    is_err = 1'b0;
    if (state == TRACK) begin
      is_cw  = (ab == cw_next(prev_ab));
      is_ccw = (prev_ab == cw_next(ab));
      is_err = ((ab ^ prev_ab) == 2'b11);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      fill_cnt  <= '0;
      prev_ab   <= '0;
      cw_pulse  <= 1'b0;
      ccw_pulse <= 1'b0;
      position  <= '0;
      err_flag  <= 1'b0;
    end else begin
      cw_pulse  <= 1'b0;
      ccw_pulse <= 1'b0;
      unique case (state)
        FILL: begin
          if (fill_cnt == 2'(SYNC_STAGES - 1)) state <= ARM;
          else fill_cnt <= fill_cnt + 2'd1;
        end
        ARM: begin
          prev_ab <= {sync_a, sync_b};
          state   <= TRACK;
        end
        TRACK: begin
          prev_ab <= ab;
          if (en && is_cw) begin
            cw_pulse <= 1'b1;
            position <= position + 1'b1;
          end else if (en && is_ccw) begin
            ccw_pulse <= 1'b1;
            position  <= position - 1'b1;
          end
        end
        default: state <= FILL;
      endcase
      // a fresh error outranks a simultaneous clear
      if (is_err) err_flag <= 1'b1;
      else if (err_clr) err_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: latency, direction, glitch, error,
// enable gating, reset and position wrap on a fast-debounce instance.
module tb_quad_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        enc_a = 1'b1;
  logic        enc_b = 1'b1;
  logic        en = 1'b1;
  logic        err_clr = 1'b0;
  logic        cw_pulse;
  logic        ccw_pulse;
  logic [15:0] position;
  logic        err_flag;
  logic        tracking;

  logic        reset2 = 1'b1;
  logic        a2 = 1'b0;
  logic        b2 = 1'b0;
  logic        cw2;
  logic        ccw2;
  logic [15:0] pos2;
  logic        err2;
  logic        trk2;

  int checks = 0;
  int failures = 0;
  int cw_n = 0, ccw_n = 0, ovl_n = 0, wide_n = 0;
  int cw2_n = 0, ccw2_n = 0, ovl2_n = 0;
  logic cw_last = 1'b0, ccw_last = 1'b0;

  quad_decoder #(.DEBOUNCE_CYCLES(4), .POS_WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .en        (en),
    .err_clr   (err_clr),
    .cw_pulse  (cw_pulse),
    .ccw_pulse (ccw_pulse),
    .position  (position),
    .err_flag  (err_flag),
    .tracking  (tracking)
  );

  quad_decoder #(.DEBOUNCE_CYCLES(1), .POS_WIDTH(16)) dut_fast (
    .clk       (clk),
    .reset     (reset2),
    .enc_a     (a2),
    .enc_b     (b2),
    .en        (1'b1),
    .err_clr   (1'b0),
    .cw_pulse  (cw2),
    .ccw_pulse (ccw2),
    .position  (pos2),
    .err_flag  (err2),
    .tracking  (trk2)
  );

  always @(negedge clk) begin
    cw_n   += int'(cw_pulse);
    ccw_n  += int'(ccw_pulse);
    ovl_n  += int'(cw_pulse & ccw_pulse);
    wide_n += int'((cw_pulse & cw_last) | (ccw_pulse & ccw_last));
    cw_last  = cw_pulse;
    ccw_last = ccw_pulse;
    cw2_n  += int'(cw2);
    ccw2_n += int'(ccw2);
    ovl2_n += int'(cw2 & ccw2);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive(input logic [1:0] v, input int n);
    {enc_a, enc_b} = v;
    hold(n);
  endtask

  int c0;
  logic [1:0] seq [4];

  initial begin
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;

    // reset with 11 held
    step();
    reset = 1'b0;
    chk("rst_track", 32'(tracking), 0);
    chk("rst_pos", 32'(position), 0);
    chk("rst_cw", 32'(cw_pulse), 0);
    step();
    chk("fill1_track", 32'(tracking), 0);
    step();
    chk("fill2_track", 32'(tracking), 0);
    step();
    chk("arm_track", 32'(tracking), 1);
    hold(10);
    chk("idle_pulses", 32'(cw_n + ccw_n), 0);
    chk("idle_err", 32'(err_flag), 0);
    chk("idle_pos", 32'(position), 0);

    // full CW cycle 11->10->00->01->11, first step timed
    enc_b = 1'b0;
    hold(6);
    chk("lat_e5", 32'(cw_pulse), 0);
    step();
    chk("lat_e6", 32'(cw_pulse), 1);
    step();
    chk("lat_e7", 32'(cw_pulse), 0);
    hold(2);
    drive(2'b00, 10);
    drive(2'b01, 10);
    drive(2'b11, 10);
    chk("cw_cycle_cnt", 32'(cw_n), 4);
    chk("cw_cycle_ccw", 32'(ccw_n), 0);
    chk("cw_cycle_pos", 32'(position), 4);

    // 3 CW then 1 CCW
    drive(2'b10, 10);
    drive(2'b00, 10);
    drive(2'b01, 10);
    drive(2'b00, 10);
    chk("mix_cw", 32'(cw_n), 7);
    chk("mix_ccw", 32'(ccw_n), 1);
    chk("mix_pos", 32'(position), 6);
    chk("mix_overlap", 32'(ovl_n), 0);
    chk("pulse_width", 32'(wide_n), 0);

    // 3-cycle glitch on A
    drive(2'b10, 3);
    drive(2'b00, 10);
    chk("glitch_pulses", 32'(cw_n + ccw_n), 8);
    chk("glitch_pos", 32'(position), 6);
    chk("glitch_err", 32'(err_flag), 0);

    // double change 00->11
    drive(2'b11, 10);
    chk("dbl_err", 32'(err_flag), 1);
    chk("dbl_pulses", 32'(cw_n + ccw_n), 8);
    chk("dbl_pos", 32'(position), 6);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr", 32'(err_flag), 0);

    // error and clear on the same edge: set wins
    err_clr = 1'b1;
    {enc_a, enc_b} = 2'b00;
    hold(7);
    chk("set_wins", 32'(err_flag), 1);
    step();
    chk("clr_after", 32'(err_flag), 0);
    err_clr = 1'b0;
    hold(2);

    // en=0 over two CW steps
    en = 1'b0;
    drive(2'b01, 10);
    drive(2'b11, 10);
    chk("en0_pulses", 32'(cw_n + ccw_n), 8);
    chk("en0_pos", 32'(position), 6);
    en = 1'b1;
    hold(10);
    chk("en1_catchup", 32'(cw_n + ccw_n), 8);
    drive(2'b10, 10);
    chk("en1_cw", 32'(cw_n), 8);
    chk("en1_pos", 32'(position), 7);

    // reset in the middle of a step
    c0 = cw_n + ccw_n;
    {enc_a, enc_b} = 2'b00;
    hold(3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_pos", 32'(position), 0);
    chk("mid_rst_cw", 32'(cw_pulse), 0);
    chk("mid_rst_trk", 32'(tracking), 0);
    step();
    chk("mid_rst_trk1", 32'(tracking), 0);
    step();
    chk("mid_rst_trk2", 32'(tracking), 0);
    step();
    chk("mid_rst_trk3", 32'(tracking), 1);
    hold(10);
    chk("mid_rst_spur", 32'(cw_n + ccw_n), 32'(c0));
    chk("mid_rst_pos2", 32'(position), 0);

    // wrap on the fast instance: one step per cycle
    step();
    reset2 = 1'b0;
    hold(6);
    chk("fast_trk", 32'(trk2), 1);
    for (int k = 1; k <= 32767; k++) begin
      {a2, b2} = seq[k % 4];
      step();
    end
    hold(6);
    chk("fast_max", 32'(pos2), 32'h7fff);
    chk("fast_cnt", 32'(cw2_n), 32767);
    {a2, b2} = seq[0];
    hold(6);
    chk("fast_wrap", 32'(pos2), 32'h8000);
    {a2, b2} = seq[3];
    hold(6);
    chk("fast_unwrap", 32'(pos2), 32'h7fff);
    chk("fast_ccw", 32'(ccw2_n), 1);
    chk("fast_overlap", 32'(ovl2_n), 0);
    chk("fast_err", 32'(err2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
